timer_arbiter: RTL and testbench
================================

# timer_arbiter

Shares a bank of NTIMER 36-bit, 10 ns-resolution trigger timers between NREQ trigger-stage requesters. Each timer has a round-robin arbiter and an optional ownership lock. Start/clear/stop commands are accepted only on the trigger FSM's `update_timers` strobe. The block sits between the advanced-trigger stages and the timer datapath, and decodes the host config writes that set each timer's limit.

## Interface
- NREQ, 4, number of requesters (2..8)
- NTIMER, 2, number of timers (1..4)
- clk  in  1  system clock; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- wrenb  in  1  config write strobe
- wraddr  in  clog2(NTIMER)+1  bit 0 selects the limit word (0: [31:0], 1: [35:32]); upper bits select the timer
- config_data  in  32  config write data
- update_timers  in  1  command-acceptance strobe from the trigger FSM
- req_valid  in  NREQ  requester i has a pending command
- req_timer  in  NREQ*clog2(NTIMER)  target timer index per requester (width 1 when NTIMER=1)
- req_cmd  in  NREQ*3  per requester: bit 0 start, bit 1 clear, bit 2 stop
- req_ready  out  NREQ  combinational grant; a command is accepted when valid & ready
- timer_elapsed  out  NTIMER  registered elapsed flag per timer
- timer_active  out  NTIMER  registered running flag per timer
- timer_owner  out  NTIMER*clog2(NREQ)  index of the last requester granted a start

## Operation
- Arbitration runs per timer and independently. Candidates: requesters with req_valid=1 and req_timer=t. No grants while update_timers=0.
- Each timer has one round-robin pointer rr[t] (reset 0). The search starts at rr[t] and ascends with wrap. At most one grant per timer per cycle. After granting requester i, rr[t] becomes (i+1) mod NREQ.
- Different timers may grant different requesters in the same cycle.
- A requester is never granted on more than one timer per cycle, because req_timer is single-valued.
- Command application (next state), in this order:
  1. start sets active.
  2. clear zeros the count and drops elapsed.
  3. stop drops active.
  - Result: start+stop together leaves the timer inactive; start+clear restarts from 0.
  - A command with no bits set is accepted and has no effect.
- Counting:
  - While active, count increments by 1 each cycle.
  - When count >= limit (unsigned 36-bit compare), next cycle: elapsed=1, active=0.
  - While elapsed=1 and inactive, count is forced to 0.
  - The count saturates only by elapsing; no wrap is reachable because the limit is at most 2^36-1.
- Owner: on an accepted start, timer_owner[t] is set to the granted index.
- Config writes:
  - A write updates limit[t] the cycle after wrenb.
  - Writing while a timer is running takes effect on the next compare.
  - Limits are not cleared by reset; power-up value is 0.
- Reset: count, active, elapsed, rr, owner and lock all clear to 0, mid-count included. req_ready is 0 during reset.

## Timing
- Start accepted in cycle n (valid & ready & update_timers) gives:
  - active=1 at n+1;
  - count=k at n+1+k;
  - elapsed=1 and active=0 at n+2+L, where L is the limit.
- L=0: elapsed is high 2 cycles after acceptance.
- Clear accepted in cycle n: elapsed=0 and count=0 at n+1.
- Stop accepted in cycle n: active=0 at n+1. The count freezes and elapsed is unchanged.
- Stop in the same cycle the limit is reached: elapsed still asserts, because the compare uses the pre-command count.
- req_ready depends combinationally on req_valid, req_timer, update_timers and registered state only. It never depends on req_cmd.

## Configuration
- Macro `TIMER_ARB_LOCK_EN` controls the ownership lock.
- With the macro defined:
  - An accepted start sets lock[t]=1.
  - While lock[t]=1, only requester timer_owner[t] is eligible on timer t; other requesters see req_ready=0 and stall.
  - lock[t] clears the cycle after the owner's accepted stop or clear, or the cycle elapsed rises.
- Without the macro: no lock state; pure round-robin among all candidates.

## Structure
- Package `timer_arb_pkg` holds:
  - CMD_START=0, CMD_CLEAR=1, CMD_STOP=2;
  - TIMER_W=36;
  - the limit-word select encoding.
- Sub-module `timer_slot` (instantiated NTIMER times) holds one timer's count, active, elapsed and limit, plus command application.
- Arbitration, round-robin pointers, lock and owner logic stay in the top level.

## Test plan
- Limit write 0x00000005 / 0x0, requester 0 starts timer 0 at cycle n -> active at n+1, elapsed=1 and active=0 at n+7; clear at n+9 -> elapsed=0 at n+10.
- Requesters 0, 1 and 2 all valid on timer 0 under continuous update_timers, lock off -> grant order 0, 1, 2, 0; timer 1 simultaneously grants requester 3 each cycle.
- update_timers=0 with req_valid=4'b1111 -> req_ready=0 and all state unchanged; assert update_timers -> exactly one grant per targeted timer.
- Single command start+stop at limit 10 -> active stays 0; start+clear while elapsed -> count restarts at 0, elapsed=0 next cycle.
- `TIMER_ARB_LOCK_EN`: requester 1 starts timer 0, requester 2 stalls (ready=0) until requester 1's stop is accepted, then requester 2 is granted the next update cycle.
- Reset asserted mid-count (count=0x123) -> next cycle count=0, active=0, elapsed=0, owner=0, rr=0; limit retains 0x5.

Source files
------------

// File: rtl/timer_arb_pkg.sv
// rtl/timer_arb_pkg.sv - shared constants for the timer arbiter
//
// Purpose : command bit positions, timer width and the limit-word select
//           encoding shared by timer_arbiter and timer_slot.
// Ports   : none (package).
package timer_arb_pkg;

  // Bit positions inside a 3-bit requester command.
  localparam int CMD_START = 0;
  localparam int CMD_CLEAR = 1;
  localparam int CMD_STOP  = 2;
  localparam int CMD_W     = 3;

  localparam int TIMER_W = 36;

  // wraddr[0] selects which half of the 36-bit limit a config write lands in.
  localparam logic LIMIT_WORD_LO = 1'b0;  // limit[31:0]
  localparam logic LIMIT_WORD_HI = 1'b1;  // limit[35:32]

endpackage

// File: rtl/timer_slot.sv
// rtl/timer_slot.sv - one 36-bit trigger timer with its limit and command application
//
// Purpose : holds count, active, elapsed and the limit register of a single
//           timer; applies counting and then the accepted command.
// Ports   : clk, reset        - clock, synchronous active-high reset
//           lo_wr, hi_wr      - write config_data into limit[31:0] / limit[35:32]
//           config_data       - host config write data
//           cmd_valid, cmd    - accepted command this cycle (start/clear/stop bits)
//           active, elapsed   - registered running / elapsed flags
//           hit               - running count has reached the limit this cycle
module timer_slot
  import timer_arb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             lo_wr,
  input  logic             hi_wr,
  input  logic [31:0]      config_data,
  input  logic             cmd_valid,
  input  logic [CMD_W-1:0] cmd,
  output logic             active,
  output logic             elapsed,
  output logic             hit
);

  logic [TIMER_W-1:0] count;
  logic [TIMER_W-1:0] limit;
  logic [TIMER_W-1:0] count_n;
  logic               active_n;
  logic               elapsed_n;

  // The compare always sees the pre-command count, so a stop arriving in the
  // same cycle the limit is reached still lets elapsed assert.
  assign hit = active && (count >= limit);

  // Limits survive reset; a write mid-run is seen by the next compare.
  always_ff @(posedge clk) begin
    if (lo_wr) limit[31:0]  <= config_data;
    if (hi_wr) limit[35:32] <= config_data[3:0];
  end

  always_comb begin
    count_n   = count;
    active_n  = active;
    elapsed_n = elapsed;

    if (active) begin
      if (hit) begin
        elapsed_n = 1'b1;
        active_n  = 1'b0;
      end else begin
        count_n = count + TIMER_W'(1);
      end
    end else if (elapsed) begin
      count_n = '0;
    end

    // Applied in start, clear, stop order: start+stop ends inactive,
    // start+clear restarts from zero.
    if (cmd_valid) begin
      if (cmd[CMD_START]) active_n = 1'b1;
      if (cmd[CMD_CLEAR]) begin
        count_n   = '0;
        elapsed_n = 1'b0;
      end
      if (cmd[CMD_STOP]) active_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      active  <= 1'b0;
      elapsed <= 1'b0;
    end else begin
      count   <= count_n;
      active  <= active_n;
      elapsed <= elapsed_n;
    end
  end

endmodule

// File: rtl/timer_arbiter.sv
// rtl/timer_arbiter.sv - round-robin sharing of NTIMER trigger timers among NREQ requesters
//
// Purpose : per-timer round-robin arbitration of start/clear/stop commands,
//           accepted only on update_timers; decodes host limit writes; tracks
//           the last starter of each timer. Optional ownership lock enabled by
//           defining TIMER_ARB_LOCK_EN.
// Ports   : clk, reset          - clock, synchronous active-high reset
//           wrenb, wraddr      - config write; wraddr[0] word select, upper bits timer
//           config_data        - config write data
//           update_timers      - command-acceptance strobe
//           req_valid          - per-requester pending command
//           req_timer          - per-requester target timer index
//           req_cmd            - per-requester command (start/clear/stop)
//           req_ready          - combinational grant per requester
//           timer_elapsed      - registered elapsed flag per timer
//           timer_active       - registered running flag per timer
//           timer_owner        - last requester granted a start, per timer
module timer_arbiter
  import timer_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int NTIMER = 2,
  localparam int TSW = (NTIMER > 1) ? $clog2(NTIMER) : 1,
  localparam int AW  = $clog2(NTIMER) + 1,
  localparam int RW  = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wrenb,
  input  logic [AW-1:0]           wraddr,
  input  logic [31:0]             config_data,
  input  logic                    update_timers,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*TSW-1:0]     req_timer,
  input  logic [NREQ*CMD_W-1:0]   req_cmd,
  output logic [NREQ-1:0]         req_ready,
  output logic [NTIMER-1:0]       timer_elapsed,
  output logic [NTIMER-1:0]       timer_active,
  output logic [NTIMER*RW-1:0]    timer_owner
);

  logic [NTIMER-1:0][RW-1:0]    rr;
  logic [NTIMER-1:0][RW-1:0]    owner;
  logic [NTIMER-1:0][NREQ-1:0]  eligible;
  logic [NTIMER-1:0][NREQ-1:0]  grant;
  logic [NTIMER-1:0][RW-1:0]    gidx;
  logic [NTIMER-1:0]            gany;
  logic [NTIMER-1:0][CMD_W-1:0] cmd_t;
  logic [NTIMER-1:0]            hit;
  logic [NTIMER-1:0]            lo_wr;
  logic [NTIMER-1:0]            hi_wr;

`ifdef TIMER_ARB_LOCK_EN
  logic [NTIMER-1:0] lock;
`else
  logic unused_hit;
  assign unused_hit = ^hit;
`endif

  // Candidate set per timer; never depends on req_cmd.
  always_comb begin
    eligible = '0;
    for (int t = 0; t < NTIMER; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        eligible[t][i] = update_timers && !reset && req_valid[i] &&
                         (int'(req_timer[i*TSW +: TSW]) == t);
`ifdef TIMER_ARB_LOCK_EN
        if (lock[t] && (owner[t] != RW'(i))) eligible[t][i] = 1'b0;
`endif
      end
    end
  end

  // Search from rr[t] upward with wrap; first eligible requester wins.
  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    gidx  = '0;
    gany  = '0;
    for (int t = 0; t < NTIMER; t++) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = int'(rr[t]) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!gany[t] && eligible[t][idx]) begin
          gany[t]       = 1'b1;
          gidx[t]       = RW'(idx);
          grant[t][idx] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    cmd_t     = '0;
    for (int t = 0; t < NTIMER; t++) begin
      req_ready = req_ready | grant[t];
      cmd_t[t]  = req_cmd[int'(gidx[t])*CMD_W +: CMD_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr    <= '0;
      owner <= '0;
    end else begin
      for (int t = 0; t < NTIMER; t++) begin
        if (gany[t]) begin
          rr[t] <= (gidx[t] == RW'(NREQ-1)) ? '0 : gidx[t] + RW'(1);
          if (cmd_t[t][CMD_START]) owner[t] <= gidx[t];
        end
      end
    end
  end

`ifdef TIMER_ARB_LOCK_EN
  // Start takes the lock; the owner's stop/clear or the timer elapsing frees it.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock <= '0;
    end else begin
      for (int t = 0; t < NTIMER; t++) begin
        lock[t] <= (lock[t] | (gany[t] & cmd_t[t][CMD_START]))
                   & ~(gany[t] & (cmd_t[t][CMD_CLEAR] | cmd_t[t][CMD_STOP]))
                   & ~hit[t];
      end
    end
  end
`endif

  assign timer_owner = owner;

  for (genvar t = 0; t < NTIMER; t++) begin : g_slot
    assign lo_wr[t] = wrenb && (wraddr[0] == LIMIT_WORD_LO) && ((wraddr >> 1) == AW'(t));
    assign hi_wr[t] = wrenb && (wraddr[0] == LIMIT_WORD_HI) && ((wraddr >> 1) == AW'(t));

    timer_slot u_slot (
      .clk         (clk),
      .reset       (reset),
      .lo_wr       (lo_wr[t]),
      .hi_wr       (hi_wr[t]),
      .config_data (config_data),
      .cmd_valid   (gany[t]),
      .cmd         (cmd_t[t]),
      .active      (timer_active[t]),
      .elapsed     (timer_elapsed[t]),
      .hit         (hit[t])
    );
  end

endmodule

// File: tb/tb_timer_arbiter.sv
// tb/tb_timer_arbiter.sv - self-checking bench for timer_arbiter (TIMER_ARB_LOCK_EN aware)
module tb_timer_arbiter;
  localparam int NREQ   = 4;
  localparam int NTIMER = 2;
  localparam int TSW    = 1;
  localparam int AW     = 2;
  localparam int RW     = 2;
`ifdef TIMER_ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic                  clk;
  logic                  reset;
  logic                  wrenb;
  logic [AW-1:0]         wraddr;
  logic [31:0]           config_data;
  logic                  update_timers;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*TSW-1:0]   req_timer;
  logic [NREQ*3-1:0]     req_cmd;
  logic [NREQ-1:0]       req_ready;
  logic [NTIMER-1:0]     timer_elapsed;
  logic [NTIMER-1:0]     timer_active;
  logic [NTIMER*RW-1:0]  timer_owner;

  timer_arbiter #(.NREQ(NREQ), .NTIMER(NTIMER)) dut (
    .clk(clk), .reset(reset), .wrenb(wrenb), .wraddr(wraddr),
    .config_data(config_data), .update_timers(update_timers),
    .req_valid(req_valid), .req_timer(req_timer), .req_cmd(req_cmd),
    .req_ready(req_ready), .timer_elapsed(timer_elapsed),
    .timer_active(timer_active), .timer_owner(timer_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural reference: per-timer state in plain arrays.
  longint unsigned m_count[NTIMER];
  longint unsigned m_limit[NTIMER];
  bit              m_act[NTIMER];
  bit              m_el[NTIMER];
  bit              m_lock[NTIMER];
  int              m_rr[NTIMER];
  int              m_owner[NTIMER];
  int              m_grant[NTIMER];

  function automatic void m_arb();
    for (int t = 0; t < NTIMER; t++) begin
      m_grant[t] = -1;
      if (update_timers && !reset) begin
        for (int k = 0; k < NREQ; k++) begin
          int i;
          i = (m_rr[t] + k) % NREQ;
          if (m_grant[t] < 0 && req_valid[i] && int'(req_timer[i*TSW +: TSW]) == t &&
              (!LOCK || !m_lock[t] || m_owner[t] == i))
            m_grant[t] = i;
        end
      end
    end
  endfunction

  function automatic void model_tick();
    m_arb();
    for (int t = 0; t < NTIMER; t++) begin
      if (reset) begin
        m_count[t] = 0; m_act[t] = 0; m_el[t] = 0;
        m_lock[t] = 0; m_rr[t] = 0; m_owner[t] = 0;
      end else begin
        bit hit, a, e, lk;
        longint unsigned c;
        int g;
        hit = m_act[t] && (m_count[t] >= m_limit[t]);
        c = m_count[t]; a = m_act[t]; e = m_el[t]; lk = m_lock[t];
        if (a) begin
          if (hit) begin e = 1; a = 0; end
          else c = c + 1;
        end else if (e) c = 0;
        g = m_grant[t];
        if (g >= 0) begin
          logic [2:0] cmd;
          cmd = req_cmd[g*3 +: 3];
          if (cmd[0]) begin a = 1; lk = 1; m_owner[t] = g; end
          if (cmd[1]) begin c = 0; e = 0; lk = 0; end
          if (cmd[2]) begin a = 0; lk = 0; end
          m_rr[t] = (g + 1) % NREQ;
        end
        if (hit) lk = 0;
        m_count[t] = c; m_act[t] = a; m_el[t] = e; m_lock[t] = lk;
      end
    end
    if (wrenb) begin
      int t;
      t = int'(wraddr >> 1);
      if (wraddr[0]) m_limit[t] = (m_limit[t] & 64'hFFFF_FFFF) | (longint'(config_data[3:0]) << 32);
      else           m_limit[t] = (m_limit[t] & 64'hF_0000_0000) | longint'(config_data);
    end
  endfunction

  // Compare combinational and registered outputs with the model, then clock once.
  task automatic step();
    logic [NREQ-1:0]      e_ready;
    logic [NTIMER-1:0]    e_el, e_act;
    logic [NTIMER*RW-1:0] e_own;
    #1;
    m_arb();
    e_ready = '0; e_el = '0; e_act = '0; e_own = '0;
    for (int t = 0; t < NTIMER; t++) begin
      if (m_grant[t] >= 0) e_ready[m_grant[t]] = 1'b1;
      e_el[t]  = m_el[t];
      e_act[t] = m_act[t];
      e_own[t*RW +: RW] = RW'(m_owner[t]);
    end
    check("ready", req_ready, e_ready);
    check("elapsed", timer_elapsed, e_el);
    check("active", timer_active, e_act);
    check("owner", timer_owner, e_own);
    @(posedge clk);
    model_tick();
    @(negedge clk);
  endtask

  task automatic idle(int n);
    req_valid = '0; wrenb = 1'b0; update_timers = 1'b0;
    for (int j = 0; j < n; j++) step();
  endtask

  task automatic wr_limit(int t, longint unsigned v);
    req_valid = '0; update_timers = 1'b0;
    wrenb = 1'b1; wraddr = AW'(t*2);     config_data = v[31:0];        step();
    wraddr = AW'(t*2 + 1); config_data = {28'd0, v[35:32]};             step();
    wrenb = 1'b0;
  endtask

  task automatic issue(int r, int t, logic [2:0] cmd);
    wrenb = 1'b0;
    req_valid = '0; req_valid[r] = 1'b1;
    req_timer[r*TSW +: TSW] = TSW'(t);
    req_cmd[r*3 +: 3] = cmd;
    update_timers = 1'b1;
    step();
    req_valid = '0; update_timers = 1'b0; req_cmd = '0;
  endtask

  task automatic do_reset();
    req_valid = '0; update_timers = 1'b0; wrenb = 1'b0;
    reset = 1'b1; step(); reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wrenb = 0; wraddr = 0; config_data = 0;
    update_timers = 0; req_valid = 0; req_timer = 0; req_cmd = 0;
    for (int t = 0; t < NTIMER; t++) begin
      m_count[t] = 0; m_limit[t] = 0; m_act[t] = 0; m_el[t] = 0;
      m_lock[t] = 0; m_rr[t] = 0; m_owner[t] = 0; m_grant[t] = -1;
    end
    @(negedge clk);
    // ready stays low in reset even with everything requesting
    req_valid = 4'b1111; update_timers = 1'b1;
    #1 check("rst_ready", req_ready, 0);
    step(); step();
    reset = 1'b0; req_valid = '0; update_timers = 1'b0;
    check("rst_active", timer_active, 0);
    check("rst_elapsed", timer_elapsed, 0);
    check("rst_owner", timer_owner, 0);

    // Limit 5: active at n+1, elapsed at n+7, clear at n+9 -> elapsed low at n+10
    wr_limit(0, 5); wr_limit(1, 5);
    issue(0, 0, 3'b001);
    check("s1_active_n1", timer_active[0], 1);
    for (int j = 1; j <= 6; j++) begin
      idle(1);
      check("s1_elapsed", timer_elapsed[0], (j == 6));
      check("s1_active", timer_active[0], (j != 6));
    end
    idle(2);
    issue(0, 0, 3'b010);
    check("s1_clear_el", timer_elapsed[0], 0);

    // Round robin: 0,1,2 on timer 0, requester 3 alone on timer 1
    do_reset();
    req_valid = 4'b1111; req_timer = 4'b1000; req_cmd = '0; update_timers = 1'b1;
    #1 check("s2_g0", req_ready, 4'b1001); step();
    #1 check("s2_g1", req_ready, 4'b1010); step();
    #1 check("s2_g2", req_ready, 4'b1100); step();
    #1 check("s2_g3", req_ready, 4'b1001); step();

    // No grants without update_timers, one per timer once it returns
    update_timers = 1'b0;
    #1 check("s3_noupd", req_ready, 0); step();
    update_timers = 1'b1;
    #1 check("s3_count", $countones(req_ready), 2);
    check("s3_ready", req_ready, 4'b1010); step();
    idle(1);

    // start+stop stays inactive; start+clear while elapsed restarts from 0
    wr_limit(0, 10);
    issue(0, 0, 3'b101);
    check("s4_startstop", timer_active[0], 0);
    issue(0, 0, 3'b001);
    idle(11);
    check("s4_el_n12", timer_elapsed[0], 1);
    issue(0, 0, 3'b011);
    check("s4_restart_el", timer_elapsed[0], 0);
    check("s4_restart_act", timer_active[0], 1);
    idle(10);
    check("s4_el_early", timer_elapsed[0], 0);
    idle(1);
    check("s4_el_again", timer_elapsed[0], 1);

`ifdef TIMER_ARB_LOCK_EN
    do_reset();
    wr_limit(0, 50);
    issue(1, 0, 3'b001);
    req_valid = 4'b0110; req_timer = 4'b0000; req_cmd = '0; update_timers = 1'b1;
    #1 check("lk_hold0", req_ready, 4'b0010); step();
    #1 check("lk_hold1", req_ready, 4'b0010); step();
    req_cmd[1*3 +: 3] = 3'b100;
    #1 check("lk_stop", req_ready, 4'b0010); step();
    req_cmd = '0;
    #1 check("lk_release", req_ready, 4'b0100); step();
    idle(1);
`endif

    // Reset mid-count at 0x123: everything clears, limits survive
    wr_limit(0, 36'h200); wr_limit(1, 5);
    issue(1, 0, 3'b001);
    idle(36'h123);
    check("s6_pre_act", timer_active[0], 1);
    check("s6_pre_own", timer_owner[RW-1:0], 1);
    do_reset();
    check("s6_act", timer_active, 0);
    check("s6_el", timer_elapsed, 0);
    check("s6_own", timer_owner, 0);
    req_valid = 4'b1111; req_timer = 4'b0000; update_timers = 1'b1;
    #1 check("s6_rr", req_ready, 4'b0001);
    req_valid = '0; update_timers = 1'b0;
    issue(2, 1, 3'b001);
    idle(5);
    check("s6_lim_early", timer_elapsed[1], 0);
    idle(1);
    check("s6_lim_kept", timer_elapsed[1], 1);
    wr_limit(0, 3);
    issue(0, 0, 3'b001);
    idle(3);
    check("s6_cnt0_early", timer_elapsed[0], 0);
    idle(1);
    check("s6_cnt0", timer_elapsed[0], 1);

    // Random traffic against the model
    do_reset();
    wr_limit(0, $urandom_range(0, 15)); wr_limit(1, $urandom_range(0, 15));
    for (int n = 0; n < 1500; n++) begin
      update_timers = ($urandom_range(0, 3) != 0);
      req_valid     = NREQ'($urandom);
      req_timer     = (NREQ*TSW)'($urandom);
      req_cmd       = (NREQ*3)'($urandom);
      wrenb         = ($urandom_range(0, 39) == 0);
      wraddr        = AW'($urandom);
      config_data   = wraddr[0] ? 32'd0 : 32'($urandom_range(0, 12));
      reset         = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
